alu_div_seq: RTL

Multi-cycle sequencer implementing RV32M DIV/DIVU/REM/REMU by driving one instance of the core's shared `ALU` through restoring shift-subtract division. It sits beside the execute stage. The pipeline stalls on `busy_o` and captures `result_o` on `done_o`. Add, subtract and the carry flag all come from the `ALU`; the block adds no second adder of its own.

---
 rtl/div_pkg.sv | 40 ++++
 rtl/alu_div_seq_if.sv | 24 ++
 rtl/ALU.sv | 36 +++
 rtl/alu_div_seq.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared types and constants for the sequential divider and the core ALU.
package div_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned CNT_W = $clog2(XLEN);

  localparam logic [XLEN-1:0]  INT_MIN  = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_NEG_A,
    S_NEG_B,
    S_LOOP,
    S_FIX,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  function automatic logic op_is_signed(input op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_div_seq_if.sv
// Request/response bundle between the execute stage and the divide sequencer.
interface alu_div_seq_if;
  import div_pkg::*;

  logic            start_i;
  op_e             op_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic            flush_i;
  logic            busy_o;
  logic            done_o;
  logic [XLEN-1:0] result_o;

  modport master (
    output start_i, op_i, a_i, b_i, flush_i,
    input  busy_o, done_o, result_o
  );

  modport slave (
    input  start_i, op_i, a_i, b_i, flush_i,
    output busy_o, done_o, result_o
  );

endinterface

// File: rtl/ALU.sv
// Core ALU shared with the execute stage: add/sub/and/or/slt with NZCV flags.
module ALU
  import div_pkg::*;
(
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [2:0]      alu_control,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            negative,
  output logic            carry,
  output logic            overflow
);

  logic [XLEN-1:0] b_eff;
  logic [XLEN:0]   sum;

  // Subtraction is a + ~b + 1, so carry=1 means no borrow (a >= b unsigned).
  always_comb begin
    b_eff    = alu_control[0] ? ~b : b;
    sum      = {1'b0, a} + {1'b0, b_eff} + {{XLEN{1'b0}}, alu_control[0]};
    overflow = ~(a[XLEN-1] ^ b[XLEN-1] ^ alu_control[0]) & (a[XLEN-1] ^ sum[XLEN-1])
               & ~alu_control[1];
    carry    = sum[XLEN] & ~alu_control[1];
    case (alu_control)
      ALU_ADD, ALU_SUB: result = sum[XLEN-1:0];
      ALU_AND:          result = a & b;
      ALU_OR:           result = a | b;
      ALU_SLT:          result = {{(XLEN-1){1'b0}}, sum[XLEN-1] ^ overflow};
      default:          result = '0;
    endcase
    zero     = (result == '0);
    negative = result[XLEN-1];
  end

endmodule

// File: rtl/alu_div_seq.sv
// RV32M DIV/DIVU/REM/REMU sequencer: restoring shift-subtract division
// driven through the shared ALU, one quotient bit per cycle.
module alu_div_seq
  import div_pkg::*;
(
  input logic          clk,
  input logic          rst,
  alu_div_seq_if.slave bus
);

  state_e           state, state_nxt;
  op_e              op_q, op_nxt;
  logic [XLEN-1:0]  q, r, d;
  logic [XLEN-1:0]  q_nxt, r_nxt, d_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             a_neg, b_neg, a_neg_nxt, b_neg_nxt;

  logic [XLEN-1:0]  alu_a, alu_b, alu_result;
  logic [2:0]       alu_ctrl;
  logic             alu_z, alu_n, alu_c, alu_v;
  logic             unused_flags;

  logic             accept, div_zero, sgn_ovf;
  logic             busy_nxt, done_nxt;
  logic [XLEN-1:0]  result_nxt;
  logic [XLEN-1:0]  r_shift;
  logic             r_msb;

  assign accept   = bus.start_i & ~bus.flush_i;
  assign div_zero = (bus.b_i == '0);
  assign sgn_ovf  = op_is_signed(bus.op_i) && (bus.a_i == INT_MIN) && (bus.b_i == '1);
  assign r_msb    = r[XLEN-1];
  assign r_shift  = {r[XLEN-2:0], q[XLEN-1]};

  ALU u_alu (
    .a           (alu_a),
    .b           (alu_b),
    .alu_control (alu_ctrl),
    .result      (alu_result),
    .zero        (alu_z),
    .negative    (alu_n),
    .carry       (alu_c),
    .overflow    (alu_v)
  );

  assign unused_flags = alu_z ^ alu_n ^ alu_v;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Next state; a flush in any state returns to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (bus.start_i) begin
          if (div_zero || sgn_ovf)         state_nxt = S_DONE;
          else if (op_is_signed(bus.op_i)) state_nxt = S_NEG_A;
          else                             state_nxt = S_LOOP;
        end
      end
      S_NEG_A: state_nxt = S_NEG_B;
      S_NEG_B: state_nxt = S_LOOP;
      S_LOOP: begin
        if (cnt == CNT_LAST) state_nxt = op_is_signed(op_q) ? S_FIX : S_DONE;
      end
      S_FIX:   state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    if (bus.flush_i) state_nxt = S_IDLE;
  end

  // ALU operand select and datapath next values.
  always_comb begin
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = ALU_ADD;
    op_nxt    = op_q;
    q_nxt     = q;
    r_nxt     = r;
    d_nxt     = d;
    cnt_nxt   = cnt;
    a_neg_nxt = a_neg;
    b_neg_nxt = b_neg;
    case (state)
      S_IDLE: begin
        if (accept) begin
          op_nxt    = bus.op_i;
          a_neg_nxt = bus.a_i[XLEN-1];
          b_neg_nxt = bus.b_i[XLEN-1];
          q_nxt     = bus.a_i;
          r_nxt     = '0;
          d_nxt     = bus.b_i;
          cnt_nxt   = '0;
          // Overflow already leaves Q=INT_MIN and R=0; only /0 needs overriding.
          if (div_zero) begin
            q_nxt = '1;
            r_nxt = bus.a_i;
          end
        end
      end
      S_NEG_A: begin
        alu_b    = q;
        alu_ctrl = ALU_SUB;
        if (a_neg) q_nxt = alu_result;
      end
      S_NEG_B: begin
        alu_b    = d;
        alu_ctrl = ALU_SUB;
        if (b_neg) d_nxt = alu_result;
      end
      S_LOOP: begin
        alu_a    = r_shift;
        alu_b    = d;
        alu_ctrl = ALU_SUB;
        cnt_nxt  = CNT_W'(cnt + 1'b1);
        if (r_msb | alu_c) begin
          r_nxt = alu_result;
          q_nxt = {q[XLEN-2:0], 1'b1};
        end else begin
          r_nxt = r_shift;
          q_nxt = {q[XLEN-2:0], 1'b0};
        end
      end
      S_FIX: begin
        alu_ctrl = ALU_SUB;
        if (op_is_rem(op_q)) begin
          alu_b = r;
          if (a_neg) r_nxt = alu_result;
        end else begin
          alu_b = q;
          if (a_neg ^ b_neg) q_nxt = alu_result;
        end
      end
      default: ;
    endcase
  end

  // Outputs are registered off the next state so result_o is valid with done_o.
  always_comb begin
    busy_nxt   = (state_nxt != S_IDLE);
    done_nxt   = (state_nxt == S_DONE);
    result_nxt = bus.result_o;
    if (done_nxt) result_nxt = op_is_rem(op_nxt) ? r_nxt : q_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q         <= OP_DIV;
      q            <= '0;
      r            <= '0;
      d            <= '0;
      cnt          <= '0;
      a_neg        <= 1'b0;
      b_neg        <= 1'b0;
      bus.busy_o   <= 1'b0;
      bus.done_o   <= 1'b0;
      bus.result_o <= '0;
    end else begin
      op_q         <= op_nxt;
      q            <= q_nxt;
      r            <= r_nxt;
      d            <= d_nxt;
      cnt          <= cnt_nxt;
      a_neg        <= a_neg_nxt;
      b_neg        <= b_neg_nxt;
      bus.busy_o   <= busy_nxt;
      bus.done_o   <= done_nxt;
      bus.result_o <= result_nxt;
    end
  end

endmodule
